// File: rtl/mux_arb.sv
// Purpose: N-channel data mux and arbiter (fixed select or round-robin) into one output register.
// Latency: one cycle from an input transfer to the data appearing on out_data/out_sel.
// Backpressure: out_ready low with out_valid high holds the output and drops every in_ready bit.
//
// Ports:
//   clk, reset_n          clock and asynchronous active-low reset
//   mode, sel             0 = fixed select on sel, 1 = round-robin over in_valid
//   in_valid/in_data      per-channel request and flattened data (channel i at [i*WIDTH +: WIDTH])
//   in_ready              one-hot accept toward the granted channel
//   out_valid/out_data/out_sel/out_ready  registered output stage with downstream handshake
//   in_last               only with MUX_ARB_LOCK_EN: end-of-packet flag per channel
//
// Optional feature macro: MUX_ARB_LOCK_EN (round-robin grant locks onto a channel for a whole packet).

module mux_arb #(
  parameter int WIDTH    = 64,
  parameter int CHANNELS = 4,
  parameter int SELW     = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      mode,
  input  logic [SELW-1:0]           sel,
  input  logic [CHANNELS-1:0]       in_valid,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
`ifdef MUX_ARB_LOCK_EN
  input  logic [CHANNELS-1:0]       in_last,
`endif
  output logic [CHANNELS-1:0]       in_ready,
  output logic                      out_valid,
  output logic [WIDTH-1:0]          out_data,
  output logic [SELW-1:0]           out_sel,
  input  logic                      out_ready
);

  // Round-robin search start; points one past the last channel that
  // completed a packet in mode 1.
  logic [SELW-1:0] rr_ptr;

  logic [SELW-1:0] rr_gnt;
  logic            rr_found;
  logic [SELW-1:0] rr_idx;

  logic [SELW-1:0] gnt;
  logic            gnt_vld;
  logic            accept;
  logic            in_xfer;
  logic            out_xfer;
  logic            pkt_last;

  // ------------------------------------------------------------------
  // Round-robin search: first requesting channel at or above rr_ptr,
  // wrapping. CHANNELS is a power of two, so SELW-bit addition wraps
  // exactly at CHANNELS.
  // ------------------------------------------------------------------
  always_comb begin
    rr_gnt   = rr_ptr;
    rr_found = 1'b0;
    rr_idx   = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      rr_idx = rr_ptr + SELW'(i);
      if (!rr_found && in_valid[rr_idx]) begin
        rr_found = 1'b1;
        rr_gnt   = rr_idx;
      end
    end
  end

`ifdef MUX_ARB_LOCK_EN
  // ------------------------------------------------------------------
  // Packet lock: once a mode-1 transfer starts a packet, the grant stays
  // on that channel until it transfers a word with in_last set. Mode-0
  // transfers never touch the lock.
  // ------------------------------------------------------------------
  typedef enum logic {
    ST_ARB,
    ST_LOCKED
  } lock_state_t;

  lock_state_t     state_q;
  lock_state_t     state_d;
  logic [SELW-1:0] lock_ch_q;
  logic [SELW-1:0] lock_ch_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_ARB;
      lock_ch_q <= '0;
    end else begin
      state_q   <= state_d;
      lock_ch_q <= lock_ch_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    lock_ch_d = lock_ch_q;
    case (state_q)
      ST_ARB: begin
        if (mode && in_xfer && !in_last[gnt]) begin
          state_d   = ST_LOCKED;
          lock_ch_d = gnt;
        end
      end
      ST_LOCKED: begin
        if (mode && in_xfer && in_last[gnt]) begin
          state_d = ST_ARB;
        end
      end
      default: begin
        state_d = ST_ARB;
      end
    endcase
  end

  assign pkt_last = in_last[gnt];

  // Grant selection with lock. A locked channel keeps the grant even if
  // it momentarily drops in_valid, so no other channel can interleave.
  always_comb begin
    gnt     = sel;
    gnt_vld = 1'b1;
    if (mode) begin
      if (state_q == ST_LOCKED) begin
        gnt     = lock_ch_q;
        gnt_vld = 1'b1;
      end else begin
        gnt     = rr_gnt;
        gnt_vld = rr_found;
      end
    end
  end
`else
  // Without packet locking every word is a complete packet.
  assign pkt_last = 1'b1;

  always_comb begin
    gnt     = sel;
    gnt_vld = 1'b1;
    if (mode) begin
      gnt     = rr_gnt;
      gnt_vld = rr_found;
    end
  end
`endif

  // ------------------------------------------------------------------
  // Handshake. The output register can take a new word when empty or
  // when its current word leaves this cycle, which gives full
  // throughput with a single stage. Mode 0 grants sel unconditionally;
  // the transfer itself still needs in_valid[sel].
  // ------------------------------------------------------------------
  assign accept = !out_valid || out_ready;

  always_comb begin
    in_ready = '0;
    if (reset_n && gnt_vld && accept) begin
      in_ready = {{(CHANNELS-1){1'b0}}, 1'b1} << gnt;
    end
  end

  assign in_xfer  = |(in_ready & in_valid);
  assign out_xfer = out_valid && out_ready;

  // ------------------------------------------------------------------
  // Round-robin pointer: moves past the granted channel only when a
  // mode-1 transfer closes a packet.
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr <= '0;
    end else if (mode && in_xfer && pkt_last) begin
      rr_ptr <= gnt + SELW'(1);
    end
  end

  // ------------------------------------------------------------------
  // Output register. A load wins over a drain, so a simultaneous in/out
  // transfer keeps out_valid high with no bubble.
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
    end else if (in_xfer) begin
      out_valid <= 1'b1;
      out_data  <= in_data[gnt*WIDTH +: WIDTH];
      out_sel   <= gnt;
    end else if (out_xfer) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_arb.sv
module tb_mux_arb;
  localparam int W  = 64;
  localparam int N  = 4;
  localparam int SW = 2;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            mode;
  logic [SW-1:0]   sel;
  logic [N-1:0]    in_valid;
  logic [N*W-1:0]  in_data;
  logic [N-1:0]    in_ready;
  logic            out_valid;
  logic [W-1:0]    out_data;
  logic [SW-1:0]   out_sel;
  logic            out_ready;
`ifdef MUX_ARB_LOCK_EN
  logic [N-1:0]    in_last;
`endif

  always #5 clk = ~clk;

  mux_arb #(.WIDTH(W), .CHANNELS(N), .SELW(SW)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .mode      (mode),
    .sel       (sel),
    .in_valid  (in_valid),
    .in_data   (in_data),
`ifdef MUX_ARB_LOCK_EN
    .in_last   (in_last),
`endif
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  int          m_ptr;
  bit          m_ov;
  logic [W-1:0] m_od;
  int          m_os;
  bit          m_lk;
  int          m_lch;

  task automatic model_reset();
    m_ptr = 0; m_ov = 0; m_od = '0; m_os = 0; m_lk = 0; m_lch = 0;
  endtask

  task automatic model_grant(output int g, output bit vld);
    g = int'(sel);
    vld = 1;
    if (mode) begin
      if (m_lk) begin
        g = m_lch;
      end else begin
        vld = 0;
        for (int k = 0; k < N; k++) begin
          int c = (m_ptr + k) % N;
          if (!vld && in_valid[c]) begin
            g = c;
            vld = 1;
          end
        end
      end
    end
  endtask

  task automatic model_step();
    int g;
    bit vld;
    bit xin;
    bit xout;
    bit last;
    model_grant(g, vld);
    xin  = vld && (!m_ov || out_ready) && in_valid[g];
    xout = m_ov && out_ready;
    last = 1;
`ifdef MUX_ARB_LOCK_EN
    last = in_last[g];
`endif
    if (xin) begin
      m_od = in_data[g*W +: W];
      m_os = g;
      m_ov = 1;
      if (mode) begin
        if (last) begin
          m_ptr = (g + 1) % N;
          m_lk  = 0;
        end else begin
          m_lk  = 1;
          m_lch = g;
        end
      end
    end else if (xout) begin
      m_ov = 0;
    end
  endtask

  // Called right after inputs were driven (shortly after a rising edge).
  task automatic run_cycle(input string tag);
    int g;
    bit vld;
    logic [N-1:0] er;
    #2;
    model_grant(g, vld);
    er = (vld && (!m_ov || out_ready)) ? (N'(1) << g) : '0;
    check({tag, " in_ready"}, 64'(in_ready), 64'(er));
    model_step();
    @(posedge clk);
    #1;
    check({tag, " out_valid"}, 64'(out_valid), 64'(m_ov));
    check({tag, " out_sel"},   64'(out_sel),   64'(m_os));
    check({tag, " out_data"},  out_data,       m_od);
  endtask

  task automatic idle_inputs();
    mode = 0; sel = '0; in_valid = '0; out_ready = 1; in_data = '0;
`ifdef MUX_ARB_LOCK_EN
    in_last = '0;
`endif
  endtask

  task automatic do_reset();
    idle_inputs();
    #2 reset_n = 0;
    #1;
    check("rst out_valid", 64'(out_valid), 64'd0);
    check("rst out_data",  out_data,       64'd0);
    check("rst out_sel",   64'(out_sel),   64'd0);
    check("rst in_ready",  64'(in_ready),  64'd0);
    model_reset();
    @(posedge clk);
    #1;
    reset_n = 1;
  endtask

  task automatic fill_data(input int tag);
    for (int c = 0; c < N; c++) in_data[c*W +: W] = {32'hD000_0000 | 32'(tag), $urandom};
  endtask

  task automatic rand_inputs();
    mode      = ($urandom_range(0, 3) != 0);
    sel       = SW'($urandom_range(0, N - 1));
    in_valid  = N'($urandom);
    out_ready = ($urandom_range(0, 9) < 7);
    fill_data(7);
`ifdef MUX_ARB_LOCK_EN
    in_last   = N'($urandom);
`endif
  endtask

  // ---------------- single-transfer vectors from reset ----------------
  typedef struct {
    bit           mode;
    logic [SW-1:0] sel;
    logic [N-1:0] vld;
    bit           ordy;
    logic [N-1:0] exp_rdy;
    bit           exp_ov;
    logic [SW-1:0] exp_os;
  } vec_t;

  vec_t tbl[8];

  initial begin
    logic [W-1:0] d_hold;
    logic [W-1:0] d_exp;
    int           seq_exp[4];

    reset_n = 1;
    idle_inputs();

    tbl[0] = '{1'b0, 2'd2, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2};
    tbl[1] = '{1'b0, 2'd1, 4'b0000, 1'b1, 4'b0010, 1'b0, 2'd0};
    tbl[2] = '{1'b0, 2'd3, 4'b1000, 1'b1, 4'b1000, 1'b1, 2'd3};
    tbl[3] = '{1'b1, 2'd2, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0};
    tbl[4] = '{1'b1, 2'd0, 4'b1100, 1'b1, 4'b0100, 1'b1, 2'd2};
    tbl[5] = '{1'b1, 2'd1, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0};
    tbl[6] = '{1'b1, 2'd0, 4'b1000, 1'b0, 4'b1000, 1'b1, 2'd3};
    tbl[7] = '{1'b0, 2'd0, 4'b1110, 1'b0, 4'b0001, 1'b0, 2'd0};

    for (int v = 0; v < 8; v++) begin
      do_reset();
      mode = tbl[v].mode; sel = tbl[v].sel; in_valid = tbl[v].vld; out_ready = tbl[v].ordy;
      fill_data(v);
      d_exp = in_data[int'(tbl[v].exp_os)*W +: W];
      #2;
      check($sformatf("vec%0d in_ready", v), 64'(in_ready), 64'(tbl[v].exp_rdy));
      @(posedge clk);
      #1;
      check($sformatf("vec%0d out_valid", v), 64'(out_valid), 64'(tbl[v].exp_ov));
      check($sformatf("vec%0d out_sel", v),   64'(out_sel),   64'(tbl[v].exp_os));
      check($sformatf("vec%0d out_data", v),  out_data,       tbl[v].exp_ov ? d_exp : 64'd0);
    end

    // ---------------- fixed select on channel 2 ----------------
    do_reset();
    for (int i = 0; i < 4; i++) begin
      mode = 0; sel = 2; in_valid = 4'b1111; out_ready = 1;
      fill_data(100 + i);
      d_exp = in_data[2*W +: W];
      run_cycle("fixed");
      check("fixed sel2 out_sel", 64'(out_sel), 64'd2);
      check("fixed sel2 out_data", out_data, d_exp);
    end

    // ---------------- round-robin fairness ----------------
    do_reset();
    for (int i = 0; i < 8; i++) begin
      mode = 1; in_valid = 4'b1111; out_ready = 1;
      fill_data(200 + i);
      run_cycle("rr_fair");
      check("rr_fair seq", 64'(out_sel), 64'(i % 4));
      check("rr_fair no idle", 64'(out_valid), 64'd1);
    end

    // ---------------- round-robin skip ----------------
    do_reset();
    for (int i = 0; i < 4; i++) begin
      mode = 1; in_valid = 4'b1001; out_ready = 1;
      fill_data(300 + i);
      run_cycle("rr_skip");
      check("rr_skip seq", 64'(out_sel), (i % 2 == 0) ? 64'd0 : 64'd3);
    end

    // ---------------- backpressure ----------------
    do_reset();
    mode = 0; sel = 1; in_valid = 4'b0010; out_ready = 1;
    fill_data(400);
    d_hold = in_data[1*W +: W];
    run_cycle("bp load");
    for (int i = 0; i < 3; i++) begin
      out_ready = 0;
      fill_data(401 + i);
      run_cycle("bp hold");
      check("bp in_ready low", 64'(in_ready), 64'd0);
      check("bp data stable", out_data, d_hold);
    end
    out_ready = 1;
    fill_data(410);
    d_exp = in_data[1*W +: W];
    #2;
    check("bp resume in_ready", 64'(in_ready), 64'b0010);
    run_cycle("bp resume");
    check("bp next word", out_data, d_exp);

    // ---------------- reset mid-operation ----------------
    do_reset();
    mode = 1; in_valid = 4'b1111; out_ready = 0;
    fill_data(500);
    run_cycle("mid load");
    run_cycle("mid hold");
    #2 reset_n = 0;
    #1;
    check("mid rst out_valid", 64'(out_valid), 64'd0);
    check("mid rst out_data",  out_data,       64'd0);
    check("mid rst out_sel",   64'(out_sel),   64'd0);
    check("mid rst in_ready",  64'(in_ready),  64'd0);
    model_reset();
    @(posedge clk);
    #1;
    reset_n = 1;
    mode = 1; in_valid = 4'b1111; out_ready = 1;
    fill_data(510);
    run_cycle("mid after");
    check("mid first grant ch0", 64'(out_sel), 64'd0);

`ifdef MUX_ARB_LOCK_EN
    // ---------------- packet lock ----------------
    do_reset();
    seq_exp = '{1, 1, 1, 2};
    for (int i = 0; i < 4; i++) begin
      mode = 1; in_valid = 4'b0110; out_ready = 1;
      in_last = (i == 2) ? 4'b0010 : 4'b0000;
      fill_data(600 + i);
      run_cycle("lock");
      check("lock seq", 64'(out_sel), 64'(seq_exp[i]));
    end
`else
    seq_exp = '{0, 0, 0, 0};
    if (seq_exp[0] != 0) $display("unexpected init");
`endif

    // ---------------- randomized run against the model ----------------
    do_reset();
    for (int i = 0; i < 600; i++) begin
      rand_inputs();
      run_cycle("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
